cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge.sv | 133 +++++++++++++
 tb/tb_cpu_mem_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: serialises CPU data and fetch requests onto one shared bus, data first; one transaction in flight.
// cpu_stall covers bus backpressure (addr_ok/data_ok); optional one-entry fetch buffer under BRIDGE_IBUF_EN.
module cpu_mem_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_DATA = 3'd2,
    I_ADDR = 3'd3,
    I_DATA = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   d_done, i_done;
  logic   pend_d, pend_i;
  logic   ibuf_hit;

`ifdef BRIDGE_IBUF_EN
  logic        ibuf_valid;
  logic [29:0] ibuf_tag;

  assign ibuf_hit = inst_sram_en & ibuf_valid & (ibuf_tag == inst_sram_addr[31:2]);

  // inst_sram_rdata doubles as the buffer data; only tag/valid live here
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ibuf_valid <= 1'b0;
      ibuf_tag   <= 30'd0;
    end else if (state == I_DATA && bus_data_ok) begin
      ibuf_valid <= 1'b1;
      ibuf_tag   <= inst_sram_addr[31:2];
    end else if (state == D_ADDR && bus_addr_ok && (|data_sram_wen) &&
                 data_sram_addr[31:2] == ibuf_tag) begin
      ibuf_valid <= 1'b0;
    end
  end
`else
  assign ibuf_hit = 1'b0;
`endif

  assign pend_d = data_sram_en & ~d_done;
  assign pend_i = inst_sram_en & ~i_done & ~ibuf_hit;

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b1;
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_wstrb = 4'h0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    case (state)
      IDLE: begin
        cpu_stall = pend_d | pend_i;
        if (pend_d)      state_nxt = D_ADDR;
        else if (pend_i) state_nxt = I_ADDR;
      end
      D_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = |data_sram_wen;
        bus_wstrb = data_sram_wen;
        bus_addr  = data_sram_addr;
        bus_wdata = data_sram_wdata;
        if (bus_addr_ok) state_nxt = D_DATA;
      end
      D_DATA: begin
        if (bus_data_ok) state_nxt = pend_i ? I_ADDR : DONE;
      end
      I_ADDR: begin
        bus_req  = 1'b1;
        bus_addr = inst_sram_addr;
        if (bus_addr_ok) state_nxt = I_DATA;
      end
      I_DATA: begin
        if (bus_data_ok) state_nxt = DONE;
      end
      DONE: begin
        cpu_stall = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        cpu_stall = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      d_done          <= 1'b0;
      i_done          <= 1'b0;
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == D_DATA && bus_data_ok) begin
        d_done <= 1'b1;
        if (data_sram_wen == 4'h0) data_sram_rdata <= bus_rdata;
      end
      if (state == I_DATA && bus_data_ok) begin
        i_done          <= 1'b1;
        inst_sram_rdata <= bus_rdata;
      end
      if (state == DONE) begin
        d_done <= 1'b0;
        i_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomised bench for cpu_mem_bridge: a bus responder with random waits plus a request-level reference model.
module tb_cpu_mem_bridge;

`ifdef BRIDGE_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  cpu_mem_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .cpu_stall(cpu_stall), .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the CPU should see after each request completes
  logic [31:0] ref_irdata = 32'h0;
  logic [31:0] ref_drdata = 32'h0;
  logic        ref_ibuf_valid = 1'b0;
  logic [29:0] ref_ibuf_tag = 30'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE/IDLE
  task automatic run_txn(input logic ie, input logic [31:0] ia,
                         input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                         input int aw0, input int dw0, input int aw1, input int dw1,
                         input logic [31:0] rd0, input logic [31:0] rd1);
    logic [31:0] q_addr [2];
    logic        q_wr   [2];
    logic [3:0]  q_strb [2];
    logic [31:0] q_wdat [2];
    logic        q_isd  [2];
    int          aw [2];
    int          dwt [2];
    logic [31:0] rd [2];
    int          n, exp_stall, k, stall_cnt, acnt, dcnt;
    bit          in_data, done, fetch_bus;

    aw[0] = aw0; aw[1] = aw1; dwt[0] = dw0; dwt[1] = dw1; rd[0] = rd0; rd[1] = rd1;
    n = 0;
    if (IBUF && de && dw != 4'h0 && ref_ibuf_valid && da[31:2] == ref_ibuf_tag) ref_ibuf_valid = 1'b0;
    fetch_bus = ie && !(IBUF && ref_ibuf_valid && ia[31:2] == ref_ibuf_tag);
    if (de) begin
      q_addr[n] = da; q_wr[n] = |dw; q_strb[n] = dw; q_wdat[n] = dwd; q_isd[n] = 1'b1;
      if (dw == 4'h0) ref_drdata = rd[n];
      n++;
    end
    if (fetch_bus) begin
      q_addr[n] = ia; q_wr[n] = 1'b0; q_strb[n] = 4'h0; q_wdat[n] = 32'h0; q_isd[n] = 1'b0;
      ref_irdata = rd[n];
      ref_ibuf_valid = 1'b1;
      ref_ibuf_tag = ia[31:2];
      n++;
    end
    exp_stall = 0;
    if (n > 0) begin
      exp_stall = 1;
      for (int i = 0; i < n; i++) exp_stall += aw[i] + dwt[i] + 2;
    end

    inst_sram_en = ie; inst_sram_addr = ia;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dwd;
    k = 0; in_data = 1'b0; acnt = 0; dcnt = 0; stall_cnt = 0; done = 1'b0;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (!cpu_stall) begin
        done = 1'b1;
        chk("done_bus_req", 32'(bus_req), 32'h0);
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("bus_txn_count", k, n);
        chk("inst_rdata", inst_sram_rdata, ref_irdata);
        chk("data_rdata", data_sram_rdata, ref_drdata);
      end else begin
        stall_cnt++;
        if (bus_req) begin
          if (in_data || k >= n) begin
            chk("req_not_expected", 32'(bus_req), 32'h0);
          end else begin
            chk("bus_addr", bus_addr, q_addr[k]);
            chk("bus_wr", 32'(bus_wr), 32'(q_wr[k]));
            chk("bus_wstrb", 32'(bus_wstrb), 32'(q_strb[k]));
            if (q_isd[k]) chk("bus_wdata", bus_wdata, q_wdat[k]);
            bus_data_ok = 1'($urandom_range(0, 1));
            if (acnt == aw[k]) begin
              bus_addr_ok = 1'b1;
              in_data = 1'b1;
              dcnt = 0;
            end else begin
              acnt++;
            end
          end
        end else if (in_data) begin
          if (dcnt == dwt[k]) begin
            bus_data_ok = 1'b1;
            bus_rdata = rd[k];
            in_data = 1'b0;
            acnt = 0;
            k++;
          end else begin
            dcnt++;
          end
        end else begin
          bus_data_ok = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk);
    end
    if (!done) chk("txn_timeout", 32'(cpu_stall), 32'h0);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #1;
  endtask

  initial begin
    logic        ie, de;
    logic [31:0] ia, da;
    logic [3:0]  dw;

    resetn = 1'b0;
    inst_sram_en = 1'b0; inst_sram_addr = 32'h0;
    data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_data_rdata", data_sram_rdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, zero waits
    run_txn(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h3C08BFAF, 32'h0);
    // Load together with fetch: data goes first
    run_txn(1'b1, 32'hBFC00004, 1'b1, 4'h0, 32'h80001000, 32'h0, 0, 0, 0, 0, 32'h12345678, 32'h24080001);
    // Store with addr_ok held off for four cycles
    run_txn(1'b0, 32'h0, 1'b1, 4'b0011, 32'h80002000, 32'hAABBCCDD, 4, 0, 0, 0, 32'h5A5A5A5A, 32'h0);
    // Fetch, refetch (buffer hit when enabled), store over it, refetch again
    run_txn(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 1, 2, 0, 0, 32'h11112222, 32'h0);
    run_txn(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h33334444, 32'h0);
    run_txn(1'b0, 32'h0, 1'b1, 4'hF, 32'hBFC00000, 32'h01020304, 0, 0, 0, 0, 32'h0, 32'h0);
    run_txn(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 0, 32'h55556666, 32'h0);

    // Reset in the middle of a fetch data phase
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00008;
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
    #1;
    chk("mid_idle_stall", 32'(cpu_stall), 32'h1);
    @(posedge clk); #1;
    chk("mid_iaddr_req", 32'(bus_req), 32'h1);
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    chk("mid_idata_req", 32'(bus_req), 32'h0);
    resetn = 1'b0;
    inst_sram_en = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    chk("rst2_bus_req", 32'(bus_req), 32'h0);
    chk("rst2_cpu_stall", 32'(cpu_stall), 32'h0);
    chk("rst2_inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst2_data_rdata", data_sram_rdata, 32'h0);
    resetn = 1'b1;
    ref_irdata = 32'h0; ref_drdata = 32'h0; ref_ibuf_valid = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 150; t++) begin
      ie = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      ia = 32'hBFC00000 + 32'(4 * $urandom_range(0, 3));
      da = $urandom_range(0, 1) ? (32'hBFC00000 + 32'(4 * $urandom_range(0, 3)))
                                : (32'h80001000 + 32'(4 * $urandom_range(0, 3)));
      dw = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_txn(ie, ia, de, dw, da, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
              $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
